// File: rtl/karatsuba_pp_gen.sv
// Digit-serial generator of the Karatsuba partial products L0=al*bl, H0=ah*bh,
// M0=(ah+al)*(bh+bl) for 255-bit operands, presented together on a valid/ready port.
module karatsuba_pp_gen #(
  parameter int unsigned DIGIT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [254:0] a,
  input  logic [254:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [253:0] H0,
  output logic [255:0] L0,
  output logic [257:0] M0
);

  localparam int unsigned NDIG = (129 + DIGIT_W - 1) / DIGIT_W;
  localparam int unsigned YW   = NDIG * DIGIT_W;
  localparam int unsigned AW   = 129 + YW;
  localparam int unsigned PW   = 129 + DIGIT_W;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(NDIG - 1);

  typedef enum logic [2:0] {StIdle, StMulL, StMulH, StMulM, StDone} state_e;

  state_e          state;
  logic [254:0]    a_r;
  logic [254:0]    b_r;
  logic [128:0]    x;
  logic [YW-1:0]   y;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   acc;

  logic [DIGIT_W-1:0] digit;
  logic [PW-1:0]      pp;
  logic [15:0]        shamt;
  logic [AW-1:0]      acc_nx;
  logic [128:0]       sum_a;
  logic [128:0]       sum_b;
  logic               last;

  assign in_ready  = (state == StIdle) && !rst;
  assign out_valid = (state == StDone);

  // y is consumed as a shift register, so the current digit is always its low slice.
  always_comb begin
    digit  = y[DIGIT_W-1:0];
    pp     = PW'(x) * PW'(digit);
    shamt  = 16'(cnt) * 16'(DIGIT_W);
    acc_nx = acc + (AW'(pp) << shamt);
    last   = (cnt == LastCnt);
    sum_a  = {2'b00, a_r[254:128]} + {1'b0, a_r[127:0]};
    sum_b  = {2'b00, b_r[254:128]} + {1'b0, b_r[127:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= StIdle;
      a_r   <= '0;
      b_r   <= '0;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
      acc   <= '0;
      H0    <= '0;
      L0    <= '0;
      M0    <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            x     <= {1'b0, a[127:0]};
            y     <= YW'({1'b0, b[127:0]});
            cnt   <= '0;
            acc   <= '0;
            state <= StMulL;
          end
        end
        StMulL, StMulH, StMulM: begin
          if (last) begin
            cnt <= '0;
            acc <= '0;
            if (state == StMulL) begin
              L0    <= acc_nx[255:0];
              x     <= {2'b00, a_r[254:128]};
              y     <= YW'({2'b00, b_r[254:128]});
              state <= StMulH;
            end else if (state == StMulH) begin
              H0    <= acc_nx[253:0];
              x     <= sum_a;
              y     <= YW'(sum_b);
              state <= StMulM;
            end else begin
              M0    <= acc_nx[257:0];
              state <= StDone;
            end
          end else begin
            acc <= acc_nx;
            cnt <= cnt + CW'(1);
            y   <= y >> DIGIT_W;
          end
        end
        StDone: begin
          if (out_ready) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_pp_gen.sv
// Self-checking bench: three instances (DIGIT_W 8, 32, 129) share stimulus and are
// checked against directed vectors and a plain-arithmetic Karatsuba model.
module tb_karatsuba_pp_gen;

  localparam int NI = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [254:0] a;
  logic [254:0] b;
  logic         in_ready_w  [NI];
  logic         out_valid_w [NI];
  logic [253:0] h0_w        [NI];
  logic [255:0] l0_w        [NI];
  logic [257:0] m0_w        [NI];

  // ceil(129/DIGIT_W) for DIGIT_W = 8, 32, 129
  int ndig [NI] = '{17, 5, 1};

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  karatsuba_pp_gen #(.DIGIT_W(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]), .a(a), .b(b),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .H0(h0_w[0]), .L0(l0_w[0]),
    .M0(m0_w[0])
  );
  karatsuba_pp_gen #(.DIGIT_W(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]), .a(a), .b(b),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .H0(h0_w[1]), .L0(l0_w[1]),
    .M0(m0_w[1])
  );
  karatsuba_pp_gen #(.DIGIT_W(129)) u_w129 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[2]), .a(a), .b(b),
    .out_valid(out_valid_w[2]), .out_ready(out_ready), .H0(h0_w[2]), .L0(l0_w[2]),
    .M0(m0_w[2])
  );

  typedef struct {
    logic [254:0] a;
    logic [254:0] b;
    logic [511:0] l;
    logic [511:0] h;
    logic [511:0] m;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int inst, input logic [511:0] got,
                       input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d got=%h exp=%h", name, inst, got, exp);
    end
  endtask

  function automatic void model(input logic [254:0] ta, input logic [254:0] tb,
                                output logic [511:0] l, output logic [511:0] h,
                                output logic [511:0] m);
    logic [511:0] ah, al, bh, bl;
    ah = 512'(ta[254:128]);
    al = 512'(ta[127:0]);
    bh = 512'(tb[254:128]);
    bl = 512'(tb[127:0]);
    l  = al * bl;
    h  = ah * bh;
    m  = (ah + al) * (bh + bl);
  endfunction

  task automatic check_idle_zero(input string name, input bit ready_exp);
    for (int i = 0; i < NI; i++) begin
      check({name, "_valid"}, i, 512'(out_valid_w[i]), 512'(0));
      check({name, "_ready"}, i, 512'(in_ready_w[i]), 512'(ready_exp));
      check({name, "_h0"}, i, 512'(h0_w[i]), 512'(0));
      check({name, "_l0"}, i, 512'(l0_w[i]), 512'(0));
      check({name, "_m0"}, i, 512'(m0_w[i]), 512'(0));
    end
  endtask

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic accept(input logic [254:0] ta, input logic [254:0] tb);
    int  w = 0;
    logic all_rdy;
    all_rdy = in_ready_w[0] && in_ready_w[1] && in_ready_w[2];
    while (!all_rdy && w < 200) begin
      @(posedge clk); #1;
      w++;
      all_rdy = in_ready_w[0] && in_ready_w[1] && in_ready_w[2];
    end
    check("accept_ready", 0, 512'(all_rdy), 512'(1));
    a = ta;
    b = tb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) check("busy_after_accept", i, 512'(in_ready_w[i]), 512'(0));
  endtask

  // mode 0: release with out_ready pulse; 1: out_ready already held high; 2: leave in DONE.
  task automatic wait_and_check(input logic [254:0] ta, input logic [254:0] tb,
                                input logic [511:0] el, input logic [511:0] eh,
                                input logic [511:0] em, input int mode);
    int           lat [NI];
    bit           bad [NI];
    int           vc  [NI];
    logic [511:0] cl  [NI];
    logic [511:0] ch  [NI];
    logic [511:0] cm  [NI];
    int           done = 0;
    for (int i = 0; i < NI; i++) begin
      lat[i] = 0; bad[i] = 1'b0; vc[i] = 0; cl[i] = '0; ch[i] = '0; cm[i] = '0;
    end
    for (int cyc = 1; cyc <= 100 && done < NI; cyc++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        if (lat[i] == 0) begin
          if (out_valid_w[i]) begin
            lat[i] = cyc;
            vc[i]  = 1;
            cl[i]  = 512'(l0_w[i]);
            ch[i]  = 512'(h0_w[i]);
            cm[i]  = 512'(m0_w[i]);
            done++;
          end else if (in_ready_w[i]) begin
            bad[i] = 1'b1;
          end
        end else if (out_valid_w[i]) begin
          vc[i]++;
        end
      end
    end
    for (int i = 0; i < NI; i++) begin
      check("latency", i, 512'(lat[i]), 512'(3 * ndig[i]));
      check("busy_ready", i, 512'(bad[i]), 512'(0));
      check("L0", i, cl[i], el);
      check("H0", i, ch[i], eh);
      check("M0", i, cm[i], em);
      check("recombine", i, (ch[i] << 256) + ((cm[i] - cl[i] - ch[i]) << 128) + cl[i],
            512'(ta) * 512'(tb));
      check("m_ge_lh", i, 512'(cm[i] >= cl[i] + ch[i]), 512'(1));
    end
    if (mode == 1) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        if (out_valid_w[i]) vc[i]++;
        check("held_ready_pulse", i, 512'(vc[i]), 512'(1));
        check("held_ready_idle", i, 512'(in_ready_w[i]), 512'(1));
      end
    end else if (mode == 0) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < NI; i++) begin
        check("release_valid", i, 512'(out_valid_w[i]), 512'(0));
        check("release_ready", i, 512'(in_ready_w[i]), 512'(1));
      end
    end
  endtask

  function automatic logic [254:0] rand_op();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0: r = '1;
      1: r[127:0] = '0;
      2: r[255:128] = '0;
      3: r[127:0] = '1;
      default: ;
    endcase
    return r[254:0];
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog inst0 got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] t127, t128, tm, el, eh, em;
    logic [254:0] ta, tb, pa, pb;
    bit           hold;

    t127 = (512'(1) << 127) - 512'(1);
    t128 = (512'(1) << 128) - 512'(1);
    tm   = (512'(3) << 127) - 512'(2);
    vecs[0] = '{a: 255'(1), b: 255'(1), l: 512'(1), h: 512'(0), m: 512'(1)};
    vecs[1] = '{a: 255'(1) << 128, b: 255'(1) << 128, l: 512'(0), h: 512'(1), m: 512'(1)};
    vecs[2] = '{a: '1, b: '1, l: t128 * t128, h: t127 * t127, m: tm * tm};
    vecs[3] = '{a: 255'(3), b: 255'(5), l: 512'(15), h: 512'(0), m: 512'(15)};
    vecs[4] = '{a: (255'(1) << 128) | 255'(1), b: (255'(1) << 128) | 255'(1),
                l: 512'(1), h: 512'(1), m: 512'(4)};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset", 1'b0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) check("ready_after_reset", i, 512'(in_ready_w[i]), 512'(1));

    for (int v = 0; v < 5; v++) begin
      accept(vecs[v].a, vecs[v].b);
      wait_and_check(vecs[v].a, vecs[v].b, vecs[v].l, vecs[v].h, vecs[v].m, 0);
    end

    // Backpressure: hold DONE with new operands offered; they must not be captured.
    ta = rand_op(); tb = rand_op();
    model(ta, tb, el, eh, em);
    accept(ta, tb);
    wait_and_check(ta, tb, el, eh, em, 2);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      a = rand_op(); b = rand_op();
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        check("bp_valid", i, 512'(out_valid_w[i]), 512'(1));
        check("bp_ready", i, 512'(in_ready_w[i]), 512'(0));
        check("bp_L0", i, 512'(l0_w[i]), el);
        check("bp_H0", i, 512'(h0_w[i]), eh);
        check("bp_M0", i, 512'(m0_w[i]), em);
      end
    end
    pa = rand_op(); pb = rand_op();
    a = pa; b = pb; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("bp_release_valid", i, 512'(out_valid_w[i]), 512'(0));
      check("bp_release_ready", i, 512'(in_ready_w[i]), 512'(1));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < NI; i++) check("bp_pending_accept", i, 512'(in_ready_w[i]), 512'(0));
    model(pa, pb, el, eh, em);
    wait_and_check(pa, pb, el, eh, em, 0);

    // Reset on the 7th edge after accept.
    accept(rand_op(), rand_op());
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_zero("midreset", 1'b0);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) check("midreset_ready", i, 512'(in_ready_w[i]), 512'(1));
    accept(vecs[3].a, vecs[3].b);
    wait_and_check(vecs[3].a, vecs[3].b, vecs[3].l, vecs[3].h, vecs[3].m, 0);

    for (int n = 0; n < 1000; n++) begin
      ta = rand_op(); tb = rand_op();
      hold = ($urandom_range(0, 3) == 0);
      model(ta, tb, el, eh, em);
      out_ready = hold;
      accept(ta, tb);
      wait_and_check(ta, tb, el, eh, em, hold ? 1 : 0);
      out_ready = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
